mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined MIPS datapath, placed directly downstream of the EX/MEM pipeline register and feeding write-back. It resolves the branch select, performs byte/half/word loads and stores against an internal data memory with a configurable number of wait states, stalls upstream while an access is in flight, and holds the MEM/WB pipeline register.

## Interface
- DEPTH_WORDS, 1024: data memory depth in 32-bit words; power of two.
- WAIT_CYCLES, 2: extra cycles per memory access; legal range 0..15.

- Clk  in  1  pipeline clock; all state updates on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- ValidIn  in  1  EX/MEM holds a real instruction.
- ALUResultIn  in  32  effective address or ALU result.
- ReadData2In  in  32  store data.
- ZeroIn, BranchSendIn  in  1 each  ALU zero flag and branch-instruction flag.
- MemReadIn, MemWriteIn  in  1 each  load and store request.
- MemSizeIn  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSignedIn  in  1  sign-extend byte/half loads.
- WriteRegIn  in  5  destination register.
- RegWriteIn, MemToRegIn  in  1 each  write-back controls.
- PCSrcOut  out  1  combinational: ValidIn & BranchSendIn & ZeroIn.
- StallOut  out  1  upstream must hold EX/MEM contents.
- ValidOut, RegWriteOut, MemToRegOut  out  1 each  MEM/WB controls.
- ReadDataOut, ALUResultOut  out  32 each  load data and passed ALU result.
- WriteRegOut  out  5  passed destination register.
- MisalignOut  out  1  exists only with MEM_MISALIGN_TRAP_EN.

## Operation
- Memory op is ValidIn & (MemReadIn | MemWriteIn). If both are set, the op is a store and ReadDataOut is 0.
- Word index is ALUResultIn[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the address wraps modulo the depth.
- Stores are lane-enabled: byte uses lane ALUResultIn[1:0], half uses ALUResultIn[1], word writes all four lanes. Unselected bytes keep their values.
- Loads extract the same lane, then zero- or sign-extend it according to MemSignedIn.
- FSM has two states, IDLE and BUSY:
  - IDLE, memory op, WAIT_CYCLES>0: assert StallOut, load counter with WAIT_CYCLES-1, go to BUSY.
  - BUSY, counter != 0: assert StallOut and decrement.
  - BUSY, counter == 0: deassert StallOut, commit the store or sample the load, load MEM/WB, return to IDLE.
- WAIT_CYCLES=0: memory ops complete in IDLE with no stall.
- Non-memory ops always complete in IDLE in one cycle.
- While StallOut=1, MEM/WB loads a bubble: ValidOut=0, RegWriteOut=0, and the other outputs hold.
- A non-valid input loads a bubble. Memory is not written for non-valid inputs.

## Timing
- Reset: all outputs and registers are 0, FSM goes to IDLE, counter is 0. Data memory contents are not reset.
- Reset asserted mid-access aborts the access; the pending store is never committed.
- Non-memory op: MEM/WB is updated on the first posedge.
- Memory op: MEM/WB is updated on posedge WAIT_CYCLES+1. StallOut is high for exactly WAIT_CYCLES cycles, starting in the cycle the op is presented.
- A store commits on the same edge that loads MEM/WB.
- A load issued the cycle after a store to the same word returns the new data.
- PCSrcOut has no register stage and is independent of StallOut.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned access is half with addr[0]=1, or word with addr[1:0]!=0.
  - Such an access completes in IDLE with no wait states, no stall, and no memory write.
  - Outputs on completion: ReadDataOut=0, RegWriteOut=0, ValidOut=1, MisalignOut=1 for that cycle.
- Undefined: the MisalignOut port is absent. Address bits below the access size are ignored: half uses addr[1] only, word ignores addr[1:0].

## Structure
- Shared package mips_mem_pkg holds:
  - MemSize encodings (MEM_BYTE, MEM_HALF, MEM_WORD);
  - FSM state type (IDLE, BUSY);
  - counter width constant (4 bits).
- Sub-module mem_lane_align, purely combinational: produces store byte enables and lane-shifted store data, and extracts and extends load data.

## Test plan
- Reset with WAIT_CYCLES=2: all outputs 0. Word store 0xDEADBEEF to 0x10 -> StallOut high 2 cycles, MEM/WB updates on edge 3; a word load from 0x10 returns 0xDEADBEEF.
- Byte store 0xAA to 0x13, then signed byte load from 0x13 -> 0xFFFFFFAA; unsigned load -> 0x000000AA; word load from 0x10 -> 0xAAADBEEF.
- Half store 0x8001 to 0x22, signed half load -> 0xFFFF8001. Word address 0x1000 with DEPTH_WORDS=1024 aliases word 0.
- BranchSendIn=1, ZeroIn=1, ValidIn=1 -> PCSrcOut=1 in the same cycle; ValidIn=0 -> PCSrcOut=0.
- Rst_n low during BUSY of a store to 0x40 -> FSM returns to IDLE, StallOut=0, and a subsequent load from 0x40 returns the old value.
- With MEM_MISALIGN_TRAP_EN, word store to 0x41 -> MisalignOut=1, RegWriteOut=0, no stall, memory unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and types for the MEM pipeline stage
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store data replication and load extraction
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  AddrLow,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemWord,
  output logic [3:0]  ByteEn,
  output logic [31:0] StoreWord,
  output logic [31:0] LoadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Store data is replicated across lanes so the enables alone pick the target bytes
  always_comb begin
    ByteEn    = 4'b0000;
    StoreWord = 32'h0;
    LoadData  = 32'h0;
    byteSel   = MemWord[8*AddrLow +: 8];
    halfSel   = AddrLow[1] ? MemWord[31:16] : MemWord[15:0];
    case (MemSize)
      MEM_BYTE: begin
        ByteEn    = 4'b0001 << AddrLow;
        StoreWord = {4{StoreData[7:0]}};
        LoadData  = {{24{MemSigned & byteSel[7]}}, byteSel};
      end
      MEM_HALF: begin
        ByteEn    = AddrLow[1] ? 4'b1100 : 4'b0011;
        StoreWord = {2{StoreData[15:0]}};
        LoadData  = {{16{MemSigned & halfSel[15]}}, halfSel};
      end
      default: begin
        ByteEn    = 4'b1111;
        StoreWord = StoreData;
        LoadData  = MemWord;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage with wait-stated data memory; optional MEM_MISALIGN_TRAP_EN
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
)
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ValidIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic        ZeroIn,
  input  logic        BranchSendIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [4:0]  WriteRegIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  output logic        PCSrcOut,
  output logic        StallOut,
  output logic        ValidOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [4:0]  WriteRegOut
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        MisalignOut
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  memState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             memOp, isLoad, misalign, complete, stall, memWe;
  logic [AW-1:0]    wordIdx;
  logic [31:0]      memWord, storeWord, loadData;
  logic [3:0]       byteEn;
  logic [31:0]      memArray [DEPTH_WORDS];

  assign PCSrcOut = ValidIn & BranchSendIn & ZeroIn;
  assign memOp    = ValidIn & (MemReadIn | MemWriteIn);
  // A simultaneous read+write is treated as a store, so only pure reads return data
  assign isLoad   = MemReadIn & ~MemWriteIn;
  assign wordIdx  = ALUResultIn[AW+1:2];
  assign memWord  = memArray[wordIdx];
  assign StallOut = stall;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memOp & ((MemSizeIn == MEM_BYTE) ? 1'b0 :
                             (MemSizeIn == MEM_HALF) ? ALUResultIn[0] : |ALUResultIn[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mem_lane_align uLaneAlign (
    .AddrLow   (ALUResultIn[1:0]),
    .MemSize   (MemSizeIn),
    .MemSigned (MemSignedIn),
    .StoreData (ReadData2In),
    .MemWord   (memWord),
    .ByteEn    (byteEn),
    .StoreWord (storeWord),
    .LoadData  (loadData)
  );

  // FSM state and wait counter register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, stall and completion decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (memOp && HAS_WAIT && !misalign) begin
          stall     = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_INIT;
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall   = 1'b1;
          cntNext = cnt - 1'b1;
        end else begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reset gates the write so an aborted access can never commit
  assign memWe = Rst_n & complete & ValidIn & MemWriteIn & ~misalign;

  // Data memory: lane-enabled write, contents deliberately not reset
  always_ff @(posedge Clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) memArray[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
      end
    end
  end

  // MEM/WB register: bubble while stalled or for invalid input, otherwise capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ValidOut     <= 1'b0;
      RegWriteOut  <= 1'b0;
      MemToRegOut  <= 1'b0;
      ReadDataOut  <= 32'h0;
      ALUResultOut <= 32'h0;
      WriteRegOut  <= 5'h0;
    end else if (stall || !ValidIn) begin
      ValidOut    <= 1'b0;
      RegWriteOut <= 1'b0;
    end else begin
      ValidOut     <= 1'b1;
      RegWriteOut  <= RegWriteIn & ~misalign;
      MemToRegOut  <= MemToRegIn;
      ReadDataOut  <= (isLoad && !misalign) ? loadData : 32'h0;
      ALUResultOut <= ALUResultIn;
      WriteRegOut  <= WriteRegIn;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalign flag is a one-cycle pulse alongside the trapped access
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) MisalignOut <= 1'b0;
    else        MisalignOut <= ~stall & ValidIn & misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ValidIn, ZeroIn, BranchSendIn, MemReadIn, MemWriteIn, MemSignedIn;
  logic        RegWriteIn, MemToRegIn;
  logic [31:0] ALUResultIn, ReadData2In;
  logic [1:0]  MemSizeIn;
  logic [4:0]  WriteRegIn;
  logic        PCSrcOut, StallOut, ValidOut, RegWriteOut, MemToRegOut;
  logic [31:0] ReadDataOut, ALUResultOut;
  logic [4:0]  WriteRegOut;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignOut;
`endif

  localparam int WAIT = 2;

  typedef struct {
    logic [31:0] readData;
    logic [31:0] aluResult;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        memToReg;
    logic        misalign;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   regIdx = 1;

  mem_stage #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .ValidIn      (ValidIn),
    .ALUResultIn  (ALUResultIn),
    .ReadData2In  (ReadData2In),
    .ZeroIn       (ZeroIn),
    .BranchSendIn (BranchSendIn),
    .MemReadIn    (MemReadIn),
    .MemWriteIn   (MemWriteIn),
    .MemSizeIn    (MemSizeIn),
    .MemSignedIn  (MemSignedIn),
    .WriteRegIn   (WriteRegIn),
    .RegWriteIn   (RegWriteIn),
    .MemToRegIn   (MemToRegIn),
    .PCSrcOut     (PCSrcOut),
    .StallOut     (StallOut),
    .ValidOut     (ValidOut),
    .RegWriteOut  (RegWriteOut),
    .MemToRegOut  (MemToRegOut),
    .ReadDataOut  (ReadDataOut),
    .ALUResultOut (ALUResultOut),
    .WriteRegOut  (WriteRegOut)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .MisalignOut  (MisalignOut)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idleInputs();
    ValidIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0;
    BranchSendIn = 1'b0; ZeroIn = 1'b0;
  endtask

  // Present one op, push its expected MEM/WB contents, wait for completion and compare
  task automatic runOp(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                       input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] expRead, input logic expMis, input int expLat,
                       input int expStall, input string name);
    exp_t e;
    exp_t got;
    int   edges = 0;
    int   stalls = 0;
    bit   done = 0;
    ValidIn = 1'b1; ALUResultIn = addr; ReadData2In = wdata;
    MemReadIn = rd; MemWriteIn = wr; MemSizeIn = size; MemSignedIn = sgn;
    WriteRegIn = 5'(regIdx); RegWriteIn = ~wr; MemToRegIn = rd;
    BranchSendIn = 1'b0; ZeroIn = 1'b0;
    e.readData = expRead; e.aluResult = addr; e.writeReg = 5'(regIdx);
    e.regWrite = ~wr & ~expMis; e.memToReg = rd; e.misalign = expMis;
    expQ.push_back(e);
    regIdx = (regIdx % 31) + 1;
    while (!done && edges < 40) begin
      @(negedge Clk);
      if (StallOut) stalls++;
      @(posedge Clk); #1;
      edges++;
      if (ValidOut) done = 1;
    end
    idleInputs();
    got = expQ.pop_front();
    vectors++;
    if (!done) begin
      $display("FAIL %s timeout: ValidOut never rose, required within 40 cycles", name);
      miscompares++;
    end
    vectors++;
    if (edges !== expLat) begin
      $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, expLat);
      miscompares++;
    end
    vectors++;
    if (stalls !== expStall) begin
      $display("FAIL %s stall: got %0d cycles, expected %0d", name, stalls, expStall);
      miscompares++;
    end
    vectors++;
    if (ReadDataOut !== got.readData) begin
      $display("FAIL %s readData: got %h, expected %h", name, ReadDataOut, got.readData);
      miscompares++;
    end
    vectors++;
    if (ALUResultOut !== got.aluResult || WriteRegOut !== got.writeReg) begin
      $display("FAIL %s passthru: got %h/%0d, expected %h/%0d", name, ALUResultOut,
               WriteRegOut, got.aluResult, got.writeReg);
      miscompares++;
    end
    vectors++;
    if (RegWriteOut !== got.regWrite || MemToRegOut !== got.memToReg) begin
      $display("FAIL %s ctrl: got rw=%b m2r=%b, expected rw=%b m2r=%b", name, RegWriteOut,
               MemToRegOut, got.regWrite, got.memToReg);
      miscompares++;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    vectors++;
    if (MisalignOut !== got.misalign) begin
      $display("FAIL %s misalign: got %b, expected %b", name, MisalignOut, got.misalign);
      miscompares++;
    end
`endif
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idleInputs();
    ALUResultIn = 32'h0; ReadData2In = 32'h0; MemSizeIn = 2'b10; MemSignedIn = 1'b0;
    WriteRegIn = 5'h0; RegWriteIn = 1'b0; MemToRegIn = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({PCSrcOut, StallOut, ValidOut, RegWriteOut, MemToRegOut} !== 5'b0 ||
        ReadDataOut !== 32'h0 || ALUResultOut !== 32'h0 || WriteRegOut !== 5'h0) begin
      $display("FAIL reset: got ctl=%b rd=%h alu=%h wr=%0d, expected all zero",
               {PCSrcOut, StallOut, ValidOut, RegWriteOut, MemToRegOut},
               ReadDataOut, ALUResultOut, WriteRegOut);
      miscompares++;
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_word();
    runOp(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "word_store");
    runOp(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, WAIT + 1, WAIT, "word_load");
  endtask

  task automatic test_byte();
    runOp(32'h13, 32'h000000AA, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "byte_store");
    runOp(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFFFFAA, 1'b0, WAIT + 1, WAIT, "byte_load_s");
    runOp(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h000000AA, 1'b0, WAIT + 1, WAIT, "byte_load_u");
    runOp(32'h12, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFFFFAD, 1'b0, WAIT + 1, WAIT, "byte_load_l2");
    runOp(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hAAADBEEF, 1'b0, WAIT + 1, WAIT, "word_after_byte");
  endtask

  task automatic test_half_alias();
    runOp(32'h22, 32'h00008001, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "half_store");
    runOp(32'h22, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 32'hFFFF8001, 1'b0, WAIT + 1, WAIT, "half_load_s");
    runOp(32'h22, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h00008001, 1'b0, WAIT + 1, WAIT, "half_load_u");
    runOp(32'h1000, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "alias_store");
    runOp(32'h0, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h12345678, 1'b0, WAIT + 1, WAIT, "alias_load");
  endtask

  task automatic test_branch();
    ValidIn = 1'b1; BranchSendIn = 1'b1; ZeroIn = 1'b1;
    MemWriteIn = 1'b1; ALUResultIn = 32'h50; MemSizeIn = 2'b10;
    #1;
    vectors++;
    if (PCSrcOut !== 1'b1 || StallOut !== 1'b1) begin
      $display("FAIL branch_taken: got pcsrc=%b stall=%b, expected 1/1", PCSrcOut, StallOut);
      miscompares++;
    end
    ValidIn = 1'b0;
    #1;
    vectors++;
    if (PCSrcOut !== 1'b0) begin
      $display("FAIL branch_invalid: got pcsrc=%b, expected 0", PCSrcOut);
      miscompares++;
    end
    idleInputs();
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] lastAlu;
    runOp(32'h0000ABCD, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1, 0, "alu_op");
    runOp(32'h30, 32'hCAFEF00D, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "rw_store");
    runOp(32'h30, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, WAIT + 1, WAIT, "rw_load");
    lastAlu = 32'h30;
    @(posedge Clk); #1;
    vectors++;
    if (ValidOut !== 1'b0 || RegWriteOut !== 1'b0 || ALUResultOut !== lastAlu) begin
      $display("FAIL bubble: got v=%b rw=%b alu=%h, expected 0/0/%h", ValidOut, RegWriteOut,
               ALUResultOut, lastAlu);
      miscompares++;
    end
  endtask

  task automatic test_reset_busy();
    runOp(32'h40, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0, WAIT + 1, WAIT, "pre_store");
    ValidIn = 1'b1; ALUResultIn = 32'h40; ReadData2In = 32'h55667788;
    MemReadIn = 1'b0; MemWriteIn = 1'b1; MemSizeIn = 2'b10;
    @(posedge Clk); #1;
    vectors++;
    if (StallOut !== 1'b1) begin
      $display("FAIL busy_stall: got %b, expected 1", StallOut);
      miscompares++;
    end
    Rst_n = 1'b0;
    idleInputs();
    #1;
    vectors++;
    if (StallOut !== 1'b0 || ValidOut !== 1'b0) begin
      $display("FAIL reset_abort: got stall=%b valid=%b, expected 0/0", StallOut, ValidOut);
      miscompares++;
    end
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    runOp(32'h40, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11223344, 1'b0, WAIT + 1, WAIT, "after_abort");
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    runOp(32'h41, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 1'b1, 1, 0, "misalign_store");
    runOp(32'h40, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11223344, 1'b0, WAIT + 1, WAIT, "misalign_check");
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_alias();
    test_branch();
    test_back_to_back();
    test_reset_busy();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
